// File: rtl/fwd_bypass_net_if.sv
// Decode/execute operand bus plus producer-stage and long-op scoreboard inputs of the bypass network.
// master drives decode and stage information; slave returns operands, stall and stall count.
interface fwd_bypass_net_if #(
    parameter int DW   = 64,
    parameter int AW   = 5,
    parameter int NRP  = 2,
    parameter int NSTG = 3,
    parameter int CNTW = 32
);
    logic                i_re;
    logic [NRP-1:0]      i_rd_en;
    logic [NRP*AW-1:0]   i_operand_addr;
    logic [NRP*DW-1:0]   i_rf_operand;
    logic [NRP*DW-1:0]   o_operand;
    logic                o_stall;
    logic [NSTG-1:0]     stg_rf_we;
    logic [NSTG*AW-1:0]  stg_rd;
    logic [NSTG-1:0]     stg_op_load;
    logic [NSTG-1:0]     stg_mem_vld;
    logic [NSTG*DW-1:0]  stg_rd_dat;
    logic [NSTG*DW-1:0]  stg_mem_dat;
    logic                lop_issue;
    logic [AW-1:0]       lop_issue_rd;
    logic                lop_done;
    logic [AW-1:0]       lop_done_rd;
    logic [CNTW-1:0]     o_stall_cnt;

    modport master (
        output i_re, i_rd_en, i_operand_addr, i_rf_operand,
        output stg_rf_we, stg_rd, stg_op_load, stg_mem_vld, stg_rd_dat, stg_mem_dat,
        output lop_issue, lop_issue_rd, lop_done, lop_done_rd,
        input  o_operand, o_stall, o_stall_cnt
    );

    modport slave (
        input  i_re, i_rd_en, i_operand_addr, i_rf_operand,
        input  stg_rf_we, stg_rd, stg_op_load, stg_mem_vld, stg_rd_dat, stg_mem_dat,
        input  lop_issue, lop_issue_rd, lop_done, lop_done_rd,
        output o_operand, o_stall, o_stall_cnt
    );
endinterface

// File: rtl/fwd_bypass_net.sv
// Operand bypass network: youngest-stage forwarding plus load-use and long-op scoreboard stalls.
// Latency: forward captured in decode cycle N, operand presented in cycle N+1; stall is same-cycle.
// Backpressure: o_stall holds decode; capture only happens on i_re with no stall, otherwise state holds.
module fwd_bypass_net #(
    parameter int DW   = 64,
    parameter int AW   = 5,
    parameter int NRP  = 2,
    parameter int NSTG = 3,
    parameter int CNTW = 32
) (
    input logic              clk,
    input logic              rst,
    fwd_bypass_net_if.slave  bus
);
    localparam int NREG = 2 ** AW;

    logic [NREG-1:0] pend;
    logic [AW-1:0]   src      [NRP];
    logic [NRP-1:0]  hit_any;
    logic [NRP-1:0]  stall_lu;
    logic [NRP-1:0]  stall_sb;
    logic [DW-1:0]   win_dat  [NRP];
    logic [NRP-1:0]  fwd_hit_r;
    logic [DW-1:0]   fwd_dat_r[NRP];
    logic [CNTW-1:0] stall_cnt;
    logic            stall;
    logic            capture;

    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            src[p] = bus.i_operand_addr[p*AW +: AW];
        end
    end

    // Walk oldest to youngest so the lowest-numbered matching stage is the final winner.
    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            hit_any[p]  = 1'b0;
            win_dat[p]  = '0;
            stall_lu[p] = 1'b0;
            for (int s = NSTG - 1; s >= 0; s--) begin
                if (bus.i_rd_en[p] && bus.stg_rf_we[s] && (src[p] != '0) &&
                    (src[p] == bus.stg_rd[s*AW +: AW])) begin
                    hit_any[p]  = 1'b1;
                    win_dat[p]  = bus.stg_op_load[s] ? bus.stg_mem_dat[s*DW +: DW]
                                                     : bus.stg_rd_dat[s*DW +: DW];
                    stall_lu[p] = bus.stg_op_load[s] & ~bus.stg_mem_vld[s];
                end
            end
            stall_sb[p] = bus.i_rd_en[p] & pend[src[p]];
        end
    end

    assign stall   = |{stall_lu, stall_sb};
    assign capture = bus.i_re & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit_r <= '0;
            for (int p = 0; p < NRP; p++) begin
                fwd_dat_r[p] <= '0;
            end
        end else if (capture) begin
            fwd_hit_r <= hit_any;
            for (int p = 0; p < NRP; p++) begin
                fwd_dat_r[p] <= win_dat[p];
            end
        end
    end

    // Issue is applied after done so a same-register issue/done pair leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (bus.lop_done) begin
                pend[bus.lop_done_rd] <= 1'b0;
            end
            if (bus.lop_issue && (bus.lop_issue_rd != '0)) begin
                pend[bus.lop_issue_rd] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        bus.o_operand = '0;
        for (int p = 0; p < NRP; p++) begin
            bus.o_operand[p*DW +: DW] = fwd_hit_r[p] ? fwd_dat_r[p] : bus.i_rf_operand[p*DW +: DW];
        end
    end

    assign bus.o_stall     = stall;
    assign bus.o_stall_cnt = stall_cnt;
endmodule

// File: tb/tb_fwd_bypass_net.sv
// Randomized bench for fwd_bypass_net: a driver pushes expected responses from a reference model,
// a monitor pops and compares them against the DUT every cycle.
module tb_fwd_bypass_net;
    localparam int DW   = 64;
    localparam int AW   = 5;
    localparam int NRP  = 2;
    localparam int NSTG = 3;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_bypass_net_if #(.DW(DW), .AW(AW), .NRP(NRP), .NSTG(NSTG), .CNTW(CNTW)) bus ();

    fwd_bypass_net #(.DW(DW), .AW(AW), .NRP(NRP), .NSTG(NSTG), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // stimulus for the next cycle
    logic            s_rst;
    logic            s_re;
    logic [NRP-1:0]  s_rd_en;
    logic [AW-1:0]   s_addr [NRP];
    logic [DW-1:0]   s_rf   [NRP];
    logic [NSTG-1:0] s_we, s_load, s_mvld;
    logic [AW-1:0]   s_rd   [NSTG];
    logic [DW-1:0]   s_rdat [NSTG];
    logic [DW-1:0]   s_mdat [NSTG];
    logic            s_li, s_ld;
    logic [AW-1:0]   s_li_rd, s_ld_rd;

    // reference model state
    bit              m_pend [2**AW];
    bit              m_fh   [NRP];
    logic [DW-1:0]   m_fd   [NRP];
    int              m_cnt;

    typedef struct {
        logic            stall;
        logic [DW-1:0]   op [NRP];
        logic [CNTW-1:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic idle();
        s_rst = 1'b0; s_re = 1'b0; s_rd_en = '0; s_we = '0; s_load = '0; s_mvld = '0;
        s_li = 1'b0; s_ld = 1'b0; s_li_rd = '0; s_ld_rd = '0;
        for (int p = 0; p < NRP; p++) begin s_addr[p] = '0; s_rf[p] = '0; end
        for (int s = 0; s < NSTG; s++) begin s_rd[s] = '0; s_rdat[s] = '0; s_mdat[s] = '0; end
    endtask

    task automatic rand_inputs();
        s_rst   = ($urandom_range(0, 199) == 0);
        s_re    = ($urandom_range(0, 3) != 0);
        s_rd_en = NRP'($urandom);
        s_we    = NSTG'($urandom);
        s_load  = '0;
        s_mvld  = NSTG'($urandom);
        for (int s = 0; s < NSTG; s++) begin
            s_load[s] = ($urandom_range(0, 3) == 0);
            s_rd[s]   = AW'($urandom_range(0, 7));
            s_rdat[s] = {$urandom, $urandom};
            s_mdat[s] = {$urandom, $urandom};
        end
        for (int p = 0; p < NRP; p++) begin
            s_addr[p] = AW'($urandom_range(0, 7));
            s_rf[p]   = {$urandom, $urandom};
        end
        s_li    = ($urandom_range(0, 7) == 0);
        s_li_rd = AW'($urandom_range(0, 7));
        s_ld    = ($urandom_range(0, 3) == 0);
        s_ld_rd = AW'($urandom_range(0, 7));
    endtask

    // Drive one cycle, predict its response, then advance the model at the clock edge.
    task automatic cycle();
        exp_t          e;
        bit            st;
        bit            anyh [NRP];
        logic [DW-1:0] val  [NRP];
        @(negedge clk);
        rst              = s_rst;
        bus.i_re         = s_re;
        bus.i_rd_en      = s_rd_en;
        bus.stg_rf_we    = s_we;
        bus.stg_op_load  = s_load;
        bus.stg_mem_vld  = s_mvld;
        bus.lop_issue    = s_li;
        bus.lop_issue_rd = s_li_rd;
        bus.lop_done     = s_ld;
        bus.lop_done_rd  = s_ld_rd;
        for (int p = 0; p < NRP; p++) begin
            bus.i_operand_addr[p*AW +: AW] = s_addr[p];
            bus.i_rf_operand[p*DW +: DW]   = s_rf[p];
        end
        for (int s = 0; s < NSTG; s++) begin
            bus.stg_rd[s*AW +: AW]      = s_rd[s];
            bus.stg_rd_dat[s*DW +: DW]  = s_rdat[s];
            bus.stg_mem_dat[s*DW +: DW] = s_mdat[s];
        end
        #1;
        if (s_rst) begin
            for (int r = 0; r < 2**AW; r++) m_pend[r] = 1'b0;
            for (int p = 0; p < NRP; p++) begin m_fh[p] = 1'b0; m_fd[p] = '0; end
            m_cnt = 0;
        end
        st = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            anyh[p] = 1'b0;
            val[p]  = '0;
            if (s_rd_en[p] && s_addr[p] != 0) begin
                for (int s = 0; s < NSTG; s++) begin
                    if (s_we[s] && s_rd[s] == s_addr[p]) begin
                        anyh[p] = 1'b1;
                        val[p]  = s_load[s] ? s_mdat[s] : s_rdat[s];
                        if (s_load[s] && !s_mvld[s]) st = 1'b1;
                        break;
                    end
                end
                if (m_pend[s_addr[p]]) st = 1'b1;
            end
        end
        e.stall = st;
        e.cnt   = CNTW'(m_cnt);
        for (int p = 0; p < NRP; p++) e.op[p] = m_fh[p] ? m_fd[p] : s_rf[p];
        exp_q.push_back(e);
        @(posedge clk);
        if (!s_rst) begin
            if (s_re && !st) begin
                for (int p = 0; p < NRP; p++) begin m_fh[p] = anyh[p]; m_fd[p] = val[p]; end
            end
            if (st && m_cnt < CMAX) m_cnt++;
            if (s_ld) m_pend[s_ld_rd] = 1'b0;
            if (s_li && s_li_rd != 0) m_pend[s_li_rd] = 1'b1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", DW'(bus.o_stall), DW'(e.stall));
                check("stall_cnt", DW'(bus.o_stall_cnt), DW'(e.cnt));
                for (int p = 0; p < NRP; p++)
                    check($sformatf("operand%0d", p), bus.o_operand[p*DW +: DW], e.op[p]);
            end
        end
    end

    initial begin : driver
        idle();
        bus.i_re = 1'b0; bus.i_rd_en = '0; bus.i_operand_addr = '0; bus.i_rf_operand = '0;
        bus.stg_rf_we = '0; bus.stg_rd = '0; bus.stg_op_load = '0; bus.stg_mem_vld = '0;
        bus.stg_rd_dat = '0; bus.stg_mem_dat = '0;
        bus.lop_issue = 1'b0; bus.lop_issue_rd = '0; bus.lop_done = 1'b0; bus.lop_done_rd = '0;

        // reset state
        idle(); s_rst = 1'b1; s_rf[0] = 64'h1234; s_rf[1] = 64'h5678; cycle();

        // youngest of three matching stages wins
        idle(); s_re = 1'b1; s_rd_en = 2'b01; s_addr[0] = 5;
        s_we = 3'b111; s_rd[0] = 5; s_rd[1] = 5; s_rd[2] = 5;
        s_rdat[0] = 64'h11; s_rdat[1] = 64'h22; s_rdat[2] = 64'h33; cycle();
        idle(); s_rf[0] = 64'h99; cycle();

        // load-use stall, then load data arrives one stage later
        idle(); s_re = 1'b1; s_rd_en = 2'b10; s_addr[1] = 7;
        s_we = 3'b001; s_rd[0] = 7; s_load = 3'b001; cycle();
        idle(); s_re = 1'b1; s_rd_en = 2'b10; s_addr[1] = 7;
        s_we = 3'b010; s_rd[1] = 7; s_load = 3'b010; s_mvld = 3'b010; s_mdat[1] = 64'hDEAD; cycle();
        idle(); cycle();

        // register 0 never forwards
        idle(); s_re = 1'b1; s_rd_en = 2'b01; s_addr[0] = 0; s_we = 3'b111;
        for (int s = 0; s < NSTG; s++) s_rdat[s] = 64'hFF;
        cycle();
        idle(); cycle();

        // long-op scoreboard: issue, stall, same-cycle issue+done, done
        idle(); s_li = 1'b1; s_li_rd = 9; cycle();
        for (int i = 0; i < 3; i++) begin idle(); s_re = 1'b1; s_rd_en = 2'b01; s_addr[0] = 9; cycle(); end
        idle(); s_re = 1'b1; s_rd_en = 2'b01; s_addr[0] = 9;
        s_li = 1'b1; s_li_rd = 9; s_ld = 1'b1; s_ld_rd = 9; cycle();
        idle(); s_re = 1'b1; s_rd_en = 2'b01; s_addr[0] = 9; s_ld = 1'b1; s_ld_rd = 9; cycle();
        idle(); s_re = 1'b1; s_rd_en = 2'b01; s_addr[0] = 9; cycle();

        // hold captured value while stages churn, then reset mid-hold
        idle(); s_re = 1'b1; s_rd_en = 2'b01; s_addr[0] = 3; s_we = 3'b001; s_rd[0] = 3;
        s_rdat[0] = 64'h44; cycle();
        for (int i = 0; i < 4; i++) begin rand_inputs(); s_rst = 1'b0; s_re = 1'b0; s_li = 1'b0; cycle(); end
        idle(); s_rst = 1'b1; s_rf[0] = 64'hABC; cycle();

        // counter saturation under a long load-use stall
        for (int i = 0; i < 20; i++) begin
            idle(); s_re = 1'b1; s_rd_en = 2'b10; s_addr[1] = 7;
            s_we = 3'b001; s_rd[0] = 7; s_load = 3'b001; cycle();
        end
        idle(); cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin rand_inputs(); cycle(); end

        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
